fp_accum: RTL and testbench

FP_ACCUM -- requirements
Module: fp_accum

---
 rtl/fp_accum_pkg.sv | 19 +
 rtl/fp_addnorm.sv | 87 ++++++++
 rtl/fp_accum.sv | 85 ++++++++
 tb/tb_fp_accum.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_accum_pkg.sv
// Shared constants and state encoding for the floating-point accumulator and its adder.
// Values are (-1)^s * m * 2^e with a signed exponent and no hidden mantissa bit.
package fp_accum_pkg;

  localparam int EXP_DEF  = 8;
  localparam int MAN_DEF  = 23;
  localparam int CNTW_DEF = 8;

  localparam logic [EXP_DEF-1:0]         EXP_MIN = {1'b1, {(EXP_DEF-1){1'b0}}};
  localparam logic [EXP_DEF-1:0]         EXP_MAX = {1'b0, {(EXP_DEF-1){1'b1}}};
  localparam logic [EXP_DEF+MAN_DEF:0]   FP_ZERO = {1'b0, EXP_MIN, {MAN_DEF{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/fp_addnorm.sv
// Combinational align / add-or-subtract / normalize of two packed {s, e, m} operands.
// Shared with the IIR feedback path, so it holds no state and no handshake.
module fp_addnorm
  import fp_accum_pkg::*;
#(
  parameter int EXP = EXP_DEF,
  parameter int MAN = MAN_DEF
) (
  input  logic [EXP+MAN:0] a_i,
  input  logic [EXP+MAN:0] b_i,
  output logic [EXP+MAN:0] sum_o
);

  // Two guard bits let carry and normalize move the exponent past its range
  // before the saturate / underflow decision is made.
  localparam int EW = EXP + 2;

  localparam logic [EXP-1:0]        EMIN   = {1'b1, {(EXP-1){1'b0}}};
  localparam logic [EXP-1:0]        EMAX   = {1'b0, {(EXP-1){1'b1}}};
  localparam logic [EXP+MAN:0]      ZERO   = {1'b0, EMIN, {MAN{1'b0}}};
  localparam logic signed [EW-1:0]  EMIN_W = {2'b11, EMIN};
  localparam logic signed [EW-1:0]  EMAX_W = {2'b00, EMAX};
  localparam logic signed [EW-1:0]  MAN_W  = EW'(MAN);

  logic                  s_a, s_b;
  logic [EXP-1:0]        e_a, e_b;
  logic [MAN-1:0]        m_a, m_b;
  logic signed [EW-1:0]  ex_a, ex_b;

  assign {s_a, e_a, m_a} = a_i;
  assign {s_b, e_b, m_b} = b_i;
  assign ex_a = {{2{e_a[EXP-1]}}, e_a};
  assign ex_b = {{2{e_b[EXP-1]}}, e_b};

  logic                  a_big, s_big, s_sml, s_res;
  logic signed [EW-1:0]  e_big, e_sml, e_dif, e_res;
  logic [MAN-1:0]        m_big, m_sml, m_aln, m_pre, m_nrm;
  logic [MAN:0]          m_sum;
  int                    lz;

  always_comb begin
    a_big = (ex_a >= ex_b);
    s_big = a_big ? s_a  : s_b;
    s_sml = a_big ? s_b  : s_a;
    e_big = a_big ? ex_a : ex_b;
    e_sml = a_big ? ex_b : ex_a;
    m_big = a_big ? m_a  : m_b;
    m_sml = a_big ? m_b  : m_a;

    e_dif = e_big - e_sml;
    m_aln = (e_dif >= MAN_W) ? '0 : (m_sml >> e_dif);
    m_sum = {1'b0, m_big} + {1'b0, m_aln};

    s_res = s_big;
    e_res = e_big;
    m_pre = '0;
    if (s_a == s_b) begin
      if (m_sum[MAN]) begin
        m_pre = m_sum[MAN:1];
        e_res = e_big + EW'(1);
      end else begin
        m_pre = m_sum[MAN-1:0];
      end
    end else if (m_big >= m_aln) begin
      m_pre = m_big - m_aln;
    end else begin
      m_pre = m_aln - m_big;
      s_res = s_sml;
    end

    // Highest set bit wins; an all-zero mantissa leaves lz = MAN.
    lz = MAN;
    for (int i = 0; i < MAN; i++) begin
      if (m_pre[i]) lz = MAN - 1 - i;
    end
    m_nrm = m_pre << lz;
    e_res = e_res - EW'(lz);

    if (m_a == '0)           sum_o = b_i;
    else if (m_b == '0)      sum_o = a_i;
    else if (m_pre == '0)    sum_o = ZERO;
    else if (e_res > EMAX_W) sum_o = {s_res, EMAX, {MAN{1'b1}}};
    else if (e_res < EMIN_W) sum_o = ZERO;
    else                     sum_o = {s_res, e_res[EXP-1:0], m_nrm};
  end

endmodule

// File: rtl/fp_accum.sv
// Streaming floating-point accumulator: sums terms until in_last, then holds the
// result with its term count until the consumer takes it.
module fp_accum
  import fp_accum_pkg::*;
#(
  parameter int EXP  = EXP_DEF,
  parameter int MAN  = MAN_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [EXP+MAN:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP+MAN:0]   out_data,
  output logic [CNTW-1:0]    out_count
);

  localparam logic [EXP+MAN:0] ZERO = {1'b0, 1'b1, {(EXP-1){1'b0}}, {MAN{1'b0}}};

  state_e            state_q, state_d;
  logic [EXP+MAN:0]  acc_q, acc_d, sum;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  fp_addnorm #(.EXP(EXP), .MAN(MAN)) u_addnorm (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (sum)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = in_data;
          cnt_d   = CNTW'(1);
          state_d = in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = sum;
          if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
          state_d = in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        // Empty the accumulator on hand-off so IDLE always means "nothing held".
        if (out_ready) begin
          acc_d   = ZERO;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = acc_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_fp_accum.sv
// Directed and randomized checks of fp_accum against a value-level reference adder.
module tb_fp_accum;
  import fp_accum_pkg::*;

  localparam int EXP = 8, MAN = 23, CNTW = 8, W = 32;

  localparam logic [W-1:0] ZERO  = {1'b0, EXP_MIN, 23'h0};
  localparam logic [W-1:0] ONE   = {1'b0, 8'hEA, 23'h400000};
  localparam logic [W-1:0] MONE  = {1'b1, 8'hEA, 23'h400000};
  localparam logic [W-1:0] TWO   = {1'b0, 8'hEB, 23'h400000};
  localparam logic [W-1:0] THREE = {1'b0, 8'hEB, 23'h600000};
  localparam logic [W-1:0] BIG2  = {1'b0, 8'h7F, 23'h400000};
  localparam logic [W-1:0] SAT   = {1'b0, EXP_MAX, 23'h7FFFFF};
  localparam logic [W-1:0] TINY  = {1'b0, 8'hD0, 23'h400000};

  logic            clk = 1'b0;
  logic            rst, in_valid, in_last, out_ready;
  logic [W-1:0]    in_data;
  logic            in_ready, out_valid;
  logic [W-1:0]    out_data;
  logic [CNTW-1:0] out_count;

  int checks = 0;
  int errors = 0;

  fp_accum #(.EXP(EXP), .MAN(MAN), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value-level reference: a = m*2^e; align to the larger exponent with truncation,
  // combine magnitudes, renormalize into [2^22, 2^23), then range-check the exponent.
  function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    int ea, eb, e, d, ti;
    longint ma, mb, mag, tl;
    bit sa, sb, s, tb;
    ma = longint'(a[22:0]); mb = longint'(b[22:0]);
    ea = int'($signed(a[30:23])); eb = int'($signed(b[30:23]));
    sa = a[31]; sb = b[31];
    if (ma == 0) return b;
    if (mb == 0) return a;
    if (eb > ea) begin
      ti = ea; ea = eb; eb = ti;
      tl = ma; ma = mb; mb = tl;
      tb = sa; sa = sb; sb = tb;
    end
    d  = ea - eb;
    mb = (d >= MAN) ? 0 : (mb >> d);
    e  = ea;
    if (sa == sb) begin mag = ma + mb; s = sa; end
    else if (ma >= mb) begin mag = ma - mb; s = sa; end
    else begin mag = mb - ma; s = sb; end
    if (mag == 0) return ZERO;
    while (mag >= (64'd1 << 23)) begin mag = mag / 2; e++; end
    while (mag <  (64'd1 << 22)) begin mag = mag * 2; e--; end
    if (e > 127)  return {s, 8'h7F, 23'h7FFFFF};
    if (e < -128) return ZERO;
    return {s, e[7:0], mag[22:0]};
  endfunction

  function automatic logic [W-1:0] rnd_term();
    logic [7:0]  e;
    logic [22:0] m;
    e = 8'(32'hE0 + $urandom_range(0, 20));
    if ($urandom_range(0, 9) == 0) e = 8'($urandom);
    m = {1'b1, 22'($urandom)};
    return {1'($urandom), e, m};
  endfunction

  // Starts and ends at posedge+1; gap inserts idle (in_valid=0) cycles first.
  task automatic send(input logic [W-1:0] d, input logic last, input int gap);
    int n;
    n = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data = d; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("send_timeout", W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [W-1:0] ed, input int ec, input int dly);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, W'(out_valid), 1);
    chk({tag, "_data"},  out_data, ed);
    chk({tag, "_count"}, W'(out_count), W'(ec));
    repeat (dly) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_released"}, W'(out_valid), 0);
  endtask

  initial begin
    logic [W-1:0] acc, term;
    int n, cnt;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", W'(out_valid), 0);
    chk("rst_ready", W'(in_ready), 1);
    chk("rst_data",  out_data, ZERO);
    chk("rst_count", W'(out_count), 0);

    // 1.0 + 1.0, with out_valid appearing right after the last acceptance
    send(ONE, 1'b0, 0);
    chk("one_one_pending", W'(out_valid), 0);
    send(ONE, 1'b1, 0);
    chk("one_one_latency", W'(out_valid), 1);
    get_result("one_one", TWO, 2, 0);

    send(THREE, 1'b0, 0); send(MONE, 1'b1, 1);
    get_result("three_m1", TWO, 2, 0);

    send(ONE, 1'b0, 0); send(MONE, 1'b1, 0);
    get_result("cancel", ZERO, 2, 1);

    // Single term held under back-pressure
    send(THREE, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", W'(out_valid), 1);
      chk("hold_data",  out_data, THREE);
      chk("hold_count", W'(out_count), 1);
      chk("hold_ready", W'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("hold_exit_valid", W'(out_valid), 0);
    chk("hold_exit_ready", W'(in_ready), 1);

    send(BIG2, 1'b0, 0); send(BIG2, 1'b1, 0);
    get_result("sat", SAT, 2, 0);

    send(ONE, 1'b0, 0); send(TINY, 1'b1, 0);
    get_result("far_shift", ONE, 2, 0);

    // Reset mid-sum while a last term is offered: the term must be dropped
    send(ONE, 1'b0, 0); send(TWO, 1'b0, 0); send(THREE, 1'b0, 0);
    chk("acc_pending", W'(out_valid), 0);
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = TWO;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("mid_rst_valid", W'(out_valid), 0);
    chk("mid_rst_ready", W'(in_ready), 1);
    chk("mid_rst_count", W'(out_count), 0);
    chk("mid_rst_data",  out_data, ZERO);
    send(THREE, 1'b1, 0);
    get_result("post_rst", THREE, 1, 0);

    // Randomized sums with gaps and output back-pressure
    for (int t = 0; t < 25; t++) begin
      n = int'($urandom_range(1, 8));
      acc = ZERO; cnt = 0;
      for (int k = 0; k < n; k++) begin
        term = rnd_term();
        acc  = (k == 0) ? term : ref_add(acc, term);
        cnt  = (cnt == 255) ? 255 : cnt + 1;
        send(term, (k == n - 1), int'($urandom_range(0, 2)));
      end
      get_result($sformatf("rnd%0d", t), acc, cnt, int'($urandom_range(0, 3)));
    end

    // Count saturation while the sum keeps accumulating
    acc = ZERO; cnt = 0;
    for (int k = 0; k < 260; k++) begin
      term = rnd_term();
      acc  = (k == 0) ? term : ref_add(acc, term);
      cnt  = (cnt == 255) ? 255 : cnt + 1;
      send(term, (k == 259), 0);
    end
    get_result("cnt_sat", acc, cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
